eth_rx_stats_poller: RTL and testbench
======================================

Name: eth_rx_stats_poller

Overview:
- AXI-lite read master that periodically sweeps the RX FIFO debug counters: corrupted at 0xC, dropped at 0x10, total at 0x14.
- Commits the three values as one atomic snapshot and computes per-sweep deltas.
- Sits between the RX FIFO AXI-lite slave and the local stats/telemetry logic.
- Handles sequencing, retriggering and error flagging so consumers never issue AXI-lite reads themselves.

Parameters:
- PERIOD_CYCLES, 1000000: cycles between automatic sweep starts; must be >= 16.
- ADDR_W, 14: AXI-lite address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- enable  in  1  enables periodic sweeps.
- trigger  in  1  single-cycle request for an immediate sweep.
- clear_err  in  1  clears the sticky error flags.
- m_axi_arvalid  out  1  AR valid.
- m_axi_arready  in  1  AR ready.
- m_axi_araddr  out  ADDR_W  read address.
- m_axi_arprot  out  3  constant 3'b000.
- m_axi_rvalid  in  1  R valid.
- m_axi_rready  out  1  R ready.
- m_axi_rdata  in  32  read data.
- m_axi_rresp  in  2  read response.
- snap_corrupted  out  32  last committed corrupted count.
- snap_dropped  out  32  last committed dropped count.
- snap_total  out  32  last committed total count.
- delta_total  out  32  snap_total minus previous snap_total.
- delta_dropped  out  32  snap_dropped minus previous snap_dropped.
- snap_valid  out  1  one-cycle pulse on commit.
- busy  out  1  high while a sweep is in progress.
- err_resp  out  1  sticky: a non-OKAY rresp was seen.
- sample_count  out  16  number of committed snapshots.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction): every output is 0; m_axi_araddr is 0; state is IDLE; timer is PERIOD_CYCLES-1; pending is 0; index is 0.
- States:
  - IDLE: busy=0.
  - ADDR: m_axi_arvalid=1; m_axi_araddr is 0xC, 0x10 or 0x14 for index 0, 1, 2; address is stable until handshake.
  - DATA: m_axi_rready=1.
  - COMMIT: one cycle.
- Sweep start:
  - Starts from IDLE when (enable and timer==0), or trigger, or pending.
  - Timer decrements every cycle while enable=1 and saturates at 0.
  - On sweep start the timer reloads to PERIOD_CYCLES-1; it keeps counting during the sweep.
  - Timer expiry and trigger in the same cycle start one sweep only.
- Trigger while busy:
  - Sets pending, which holds at most one request.
  - pending clears when the next sweep starts.
  - Further triggers while pending=1 are absorbed.
- Enable deasserted: the timer freezes; a sweep already in progress completes.
- ADDR -> DATA on m_axi_arvalid & m_axi_arready. Only one outstanding read at a time; arvalid is never dropped before handshake.
- DATA, on m_axi_rvalid & m_axi_rready:
  - rdata is latched into shadow[index].
  - If rresp != 2'b00, the sweep-error bit is set.
  - If index<2: index increments and the FSM returns to ADDR. Otherwise: COMMIT.
- COMMIT:
  - If the sweep-error bit is clear:
    - snap_* <= shadow.
    - delta_total <= shadow_total - snap_total (old), modulo 2^32, so counter wrap gives the correct small delta.
    - delta_dropped is computed the same way.
    - snap_valid=1 for this cycle.
    - sample_count increments, wrapping at 16'hFFFF -> 0.
  - If the sweep-error bit is set: snapshot and deltas are unchanged; err_resp <= 1; no snap_valid.
  - In both cases: index <= 0, sweep-error <= 0, next state IDLE.
  - The first commit after reset produces deltas equal to the raw values, since the old snapshot is 0.
- Minimum sweep with a zero-wait slave is 3x(ADDR 1 + DATA >= 1) + COMMIT 1 cycles. The slave's SELECT stage adds 1 cycle per read, giving 10 cycles total; busy stays high throughout.
- err_resp:
  - Cleared by clear_err.
  - If clear_err coincides with an erroring COMMIT, the set wins.

Test Plan:
- Bench setup: slave model with fixed 2-cycle R latency returning 5, 3 and 100 for 0xC, 0x10 and 0x14.
- Reset, then trigger pulse -> AR addresses 0xC, 0x10, 0x14 in order; then snap_valid pulse with snap_corrupted=5, snap_dropped=3, snap_total=100, delta_total=100, sample_count=1.
- Slave updates total to 0x00000010 from old 0xFFFFFFF0, then trigger -> delta_total=0x20, snap_valid once.
- Slave holds arready=0 for 20 cycles -> arvalid and araddr stay stable; the sweep completes correctly after release.
- Slave returns rresp=2'b10 on 0x10 -> all three reads still occur; no snap_valid; snapshot unchanged; err_resp=1. Then clear_err -> err_resp=0.
- PERIOD_CYCLES=64, enable=1, trigger asserted twice mid-sweep -> exactly one extra back-to-back sweep; periodic sweeps start 64 cycles apart.
- rst asserted while in DATA -> arvalid, rready, busy and snap_valid go 0 immediately; after release, the next trigger gives a full correct sweep with sample_count=1.

Source files
------------

// File: rtl/eth_rx_stats_poller.sv
// AXI-lite read master that periodically sweeps the RX FIFO debug counters
// (corrupted/dropped/total), commits them as one snapshot and produces per-sweep deltas.
module eth_rx_stats_poller #(
    parameter int unsigned PERIOD_CYCLES = 1000000,
    parameter int unsigned ADDR_W        = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              trigger,
    input  logic              clear_err,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [2:0]        m_axi_arprot,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    output logic [31:0]       snap_corrupted,
    output logic [31:0]       snap_dropped,
    output logic [31:0]       snap_total,
    output logic [31:0]       delta_total,
    output logic [31:0]       delta_dropped,
    output logic              snap_valid,
    output logic              busy,
    output logic              err_resp,
    output logic [15:0]       sample_count
);
    localparam int unsigned TW = $clog2(PERIOD_CYCLES);
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(PERIOD_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ADDR   = 2'd1;
    localparam logic [1:0] S_DATA   = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             pending_q, pending_d;
    logic [1:0]       idx_q;
    logic             serr_q;
    logic [2:0][31:0] shadow_q;
    logic [31:0]      snap_c_q, snap_d_q, snap_t_q, dtot_q, ddrop_q;
    logic             snap_valid_q, err_q;
    logic [15:0]      count_q;
    logic             start, ar_hs, r_hs, commit;
    logic [ADDR_W-1:0] addr_sel;

    assign ar_hs  = m_axi_arvalid & m_axi_arready;
    assign r_hs   = m_axi_rvalid & m_axi_rready;
    assign commit = (state_q == S_COMMIT);
    assign start  = (state_q == S_IDLE) && ((enable && timer_q == '0) || trigger || pending_q);

    always_comb begin
        case (idx_q)
            2'd0:    addr_sel = ADDR_W'(12'hC);
            2'd1:    addr_sel = ADDR_W'(12'h10);
            default: addr_sel = ADDR_W'(12'h14);
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_ADDR;
            S_ADDR:   if (ar_hs) state_d = S_DATA;
            S_DATA:   if (r_hs)  state_d = (idx_q == 2'd2) ? S_COMMIT : S_ADDR;
            default:  state_d = S_IDLE;
        endcase
    end

    // Timer keeps running through a sweep; only enable freezes it.
    always_comb begin
        timer_d = timer_q;
        if (start)
            timer_d = TIMER_RELOAD;
        else if (enable && timer_q != '0)
            timer_d = timer_q - 1'b1;
        pending_d = pending_q;
        if (start)
            pending_d = 1'b0;
        else if (trigger && state_q != S_IDLE)
            pending_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            timer_q      <= TIMER_RELOAD;
            pending_q    <= 1'b0;
            idx_q        <= 2'd0;
            serr_q       <= 1'b0;
            shadow_q     <= '0;
            snap_c_q     <= '0;
            snap_d_q     <= '0;
            snap_t_q     <= '0;
            dtot_q       <= '0;
            ddrop_q      <= '0;
            snap_valid_q <= 1'b0;
            err_q        <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            pending_q    <= pending_d;
            snap_valid_q <= 1'b0;
            if (state_q == S_DATA && r_hs) begin
                shadow_q[idx_q] <= m_axi_rdata;
                if (m_axi_rresp != 2'b00) serr_q <= 1'b1;
                if (idx_q != 2'd2) idx_q <= idx_q + 1'b1;
            end
            if (commit) begin
                idx_q  <= 2'd0;
                serr_q <= 1'b0;
                if (!serr_q) begin
                    snap_c_q     <= shadow_q[0];
                    snap_d_q     <= shadow_q[1];
                    snap_t_q     <= shadow_q[2];
                    // Modulo-2^32 subtraction gives the right delta across counter wrap.
                    dtot_q       <= shadow_q[2] - snap_t_q;
                    ddrop_q      <= shadow_q[1] - snap_d_q;
                    snap_valid_q <= 1'b1;
                    count_q      <= count_q + 1'b1;
                end
            end
            if (commit && serr_q)
                err_q <= 1'b1;
            else if (clear_err)
                err_q <= 1'b0;
        end
    end

    assign m_axi_arvalid  = (state_q == S_ADDR);
    assign m_axi_araddr   = (state_q == S_ADDR) ? addr_sel : '0;
    assign m_axi_arprot   = 3'b000;
    assign m_axi_rready   = (state_q == S_DATA);
    assign busy           = (state_q != S_IDLE);
    assign snap_corrupted = snap_c_q;
    assign snap_dropped   = snap_d_q;
    assign snap_total     = snap_t_q;
    assign delta_total    = dtot_q;
    assign delta_dropped  = ddrop_q;
    assign snap_valid     = snap_valid_q;
    assign err_resp       = err_q;
    assign sample_count   = count_q;
endmodule

// File: tb/tb_eth_rx_stats_poller.sv
// Directed bench for eth_rx_stats_poller: table of sweeps against a 2-cycle-latency
// AXI-lite slave model, plus hand sequences for stall, retrigger, periodic and reset cases.
module tb_eth_rx_stats_poller;
    logic        clk = 1'b0;
    logic        rst, enable, trigger, clear_err;
    logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
    logic [13:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic [31:0] snap_corrupted, snap_dropped, snap_total, delta_total, delta_dropped;
    logic        snap_valid, busy, err_resp;
    logic [15:0] sample_count;

    eth_rx_stats_poller #(.PERIOD_CYCLES(64), .ADDR_W(14)) dut (
        .clk(clk), .rst(rst), .enable(enable), .trigger(trigger), .clear_err(clear_err),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .snap_corrupted(snap_corrupted), .snap_dropped(snap_dropped), .snap_total(snap_total),
        .delta_total(delta_total), .delta_dropped(delta_dropped), .snap_valid(snap_valid),
        .busy(busy), .err_resp(err_resp), .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Slave model: fixed R latency, per-address counter values, optional SLVERR on 0x10.
    logic [31:0] s_corr = 0, s_drop = 0, s_tot = 0;
    bit          s_err = 0;
    bit          ar_hold = 0;
    logic [13:0] s_addr;
    logic        s_busy;
    int          s_cnt;
    logic [13:0] ar_log[$];

    assign m_axi_arready = !ar_hold;

    function automatic logic [31:0] rd(input logic [13:0] a);
        case (a)
            14'hC:   return s_corr;
            14'h10:  return s_drop;
            14'h14:  return s_tot;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axi_rvalid <= 1'b0;
            m_axi_rdata  <= '0;
            m_axi_rresp  <= '0;
            s_busy       <= 1'b0;
            s_cnt        <= 0;
            s_addr       <= '0;
        end else begin
            if (m_axi_arvalid && m_axi_arready) begin
                s_addr <= m_axi_araddr;
                s_busy <= 1'b1;
                s_cnt  <= 2;
                ar_log.push_back(m_axi_araddr);
            end else if (s_busy && !m_axi_rvalid) begin
                if (s_cnt > 1) s_cnt <= s_cnt - 1;
                else begin
                    m_axi_rvalid <= 1'b1;
                    m_axi_rdata  <= rd(s_addr);
                    m_axi_rresp  <= (s_err && s_addr == 14'h10) ? 2'b10 : 2'b00;
                end
            end
            if (m_axi_rvalid && m_axi_rready) begin
                m_axi_rvalid <= 1'b0;
                s_busy       <= 1'b0;
            end
        end
    end

    // Monitors: cycle count, snap_valid pulses, sweep starts (busy rising).
    int cyc = 0;
    int sv_cnt = 0;
    int starts = 0;
    int start_q[$];
    logic busy_prev = 1'b0;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (snap_valid) sv_cnt++;
        if (busy && !busy_prev) begin
            starts++;
            start_q.push_back(cyc);
        end
        busy_prev = busy;
    end

    task automatic pulse_trigger();
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic run_sweep(input string tag);
        bit ok = 0;
        ar_log.delete();
        pulse_trigger();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        chk({tag, "_done"}, 32'(ok), 32'd1);
        @(negedge clk);
    endtask

    task automatic chk_addrs(input string tag);
        chk({tag, "_nreads"}, 32'(ar_log.size()), 32'd3);
        if (ar_log.size() == 3) begin
            chk({tag, "_ar0"}, 32'(ar_log[0]), 32'hC);
            chk({tag, "_ar1"}, 32'(ar_log[1]), 32'h10);
            chk({tag, "_ar2"}, 32'(ar_log[2]), 32'h14);
        end
    endtask

    typedef struct {
        logic [31:0] corr, drop, tot;
        bit          rerr;
        logic [31:0] e_corr, e_drop, e_tot, e_dtot, e_ddrop;
        logic [15:0] e_cnt;
        bit          e_err;
        int          e_pulses;
    } vec_t;
    vec_t vecs[5];

    initial begin
        int p0, s0;
        bit ok;
        vecs[0] = '{32'd5, 32'd3, 32'd100, 1'b0, 32'd5, 32'd3, 32'd100, 32'd100, 32'd3, 16'd1, 1'b0, 1};
        vecs[1] = '{32'd5, 32'd3, 32'hFFFF_FFF0, 1'b0, 32'd5, 32'd3, 32'hFFFF_FFF0, 32'hFFFF_FF8C, 32'd0, 16'd2, 1'b0, 1};
        vecs[2] = '{32'd6, 32'd8, 32'h10, 1'b0, 32'd6, 32'd8, 32'h10, 32'h20, 32'd5, 16'd3, 1'b0, 1};
        vecs[3] = '{32'd9, 32'd9, 32'd9, 1'b1, 32'd6, 32'd8, 32'h10, 32'h20, 32'd5, 16'd3, 1'b1, 0};
        vecs[4] = '{32'd10, 32'd20, 32'h30, 1'b0, 32'd10, 32'd20, 32'h30, 32'h20, 32'd12, 16'd4, 1'b0, 1};

        rst = 1'b1; enable = 1'b0; trigger = 1'b0; clear_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_arvalid", 32'(m_axi_arvalid), 32'd0);
        chk("rst_araddr", 32'(m_axi_araddr), 32'd0);
        chk("rst_rready", 32'(m_axi_rready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_snap_total", snap_total, 32'd0);
        chk("rst_delta_total", delta_total, 32'd0);
        chk("rst_count", 32'(sample_count), 32'd0);
        chk("rst_err", 32'(err_resp), 32'd0);
        chk("rst_arprot", 32'(m_axi_arprot), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            string t;
            t = $sformatf("v%0d", v);
            s_corr = vecs[v].corr; s_drop = vecs[v].drop; s_tot = vecs[v].tot; s_err = vecs[v].rerr;
            p0 = sv_cnt;
            run_sweep(t);
            chk_addrs(t);
            chk({t, "_corr"}, snap_corrupted, vecs[v].e_corr);
            chk({t, "_drop"}, snap_dropped, vecs[v].e_drop);
            chk({t, "_total"}, snap_total, vecs[v].e_tot);
            chk({t, "_dtot"}, delta_total, vecs[v].e_dtot);
            chk({t, "_ddrop"}, delta_dropped, vecs[v].e_ddrop);
            chk({t, "_count"}, 32'(sample_count), 32'(vecs[v].e_cnt));
            chk({t, "_err"}, 32'(err_resp), 32'(vecs[v].e_err));
            chk({t, "_pulses"}, 32'(sv_cnt - p0), 32'(vecs[v].e_pulses));
            s_err = 0;
            if (vecs[v].rerr) begin
                clear_err = 1'b1;
                @(negedge clk);
                clear_err = 1'b0;
                chk({t, "_cleared"}, 32'(err_resp), 32'd0);
            end
        end

        // AR stall: address must hold while arready is low.
        s_corr = 11; s_drop = 22; s_tot = 32'h40;
        ar_hold = 1;
        ar_log.delete();
        pulse_trigger();
        for (int i = 0; i < 20; i++) begin
            chk("stall_arvalid", 32'(m_axi_arvalid), 32'd1);
            chk("stall_araddr", 32'(m_axi_araddr), 32'hC);
            @(negedge clk);
        end
        ar_hold = 0;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        chk("stall_done", 32'(ok), 32'd1);
        @(negedge clk);
        chk_addrs("stall");
        chk("stall_total", snap_total, 32'h40);
        chk("stall_dtot", delta_total, 32'h10);
        chk("stall_ddrop", delta_dropped, 32'd2);
        chk("stall_count", 32'(sample_count), 32'd5);

        // Two triggers mid-sweep collapse into a single extra sweep.
        s0 = starts; p0 = sv_cnt;
        pulse_trigger();
        repeat (3) @(negedge clk);
        pulse_trigger();
        repeat (2) @(negedge clk);
        pulse_trigger();
        repeat (100) @(negedge clk);
        chk("retrig_starts", 32'(starts - s0), 32'd2);
        chk("retrig_pulses", 32'(sv_cnt - p0), 32'd2);
        chk("retrig_count", 32'(sample_count), 32'd7);

        // Periodic sweeps 64 cycles apart.
        start_q.delete();
        enable = 1'b1;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (start_q.size() >= 3) begin ok = 1; break; end
        end
        enable = 1'b0;
        chk("periodic_seen", 32'(ok), 32'd1);
        if (start_q.size() >= 3) begin
            chk("periodic_gap1", 32'(start_q[1] - start_q[0]), 32'd64);
            chk("periodic_gap2", 32'(start_q[2] - start_q[1]), 32'd64);
        end
        repeat (40) @(negedge clk);
        chk("periodic_idle", 32'(busy), 32'd0);

        // Reset in the middle of a DATA phase.
        pulse_trigger();
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (m_axi_rready) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("mid_reached_data", 32'(ok), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_arvalid", 32'(m_axi_arvalid), 32'd0);
        chk("mid_rready", 32'(m_axi_rready), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_snap_valid", 32'(snap_valid), 32'd0);
        chk("mid_count", 32'(sample_count), 32'd0);
        chk("mid_total", snap_total, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        s_corr = 5; s_drop = 3; s_tot = 100;
        p0 = sv_cnt;
        run_sweep("post");
        chk_addrs("post");
        chk("post_corr", snap_corrupted, 32'd5);
        chk("post_drop", snap_dropped, 32'd3);
        chk("post_total", snap_total, 32'd100);
        chk("post_dtot", delta_total, 32'd100);
        chk("post_count", 32'(sample_count), 32'd1);
        chk("post_pulses", 32'(sv_cnt - p0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
